// File: rtl/link_sync_ctrl_pkg.sv
// Shared link definitions: idle/alignment byte and sequencer state encoding.
// The transmit-side sequencer imports the same package.
package link_sync_ctrl_pkg;

    localparam logic [7:0] COMMA_BYTE = 8'hBC;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_HUNT     = 2'd1,
        ST_ACTIVE   = 2'd2
    } link_state_t;

endpackage

// File: rtl/link_sync_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LIMIT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/link_sync_ctrl.sv
// Receive-side link sequencer: comma hunt, payload forwarding and
// loss-of-sync detection in the byte clock domain.
module link_sync_ctrl
    import link_sync_ctrl_pkg::*;
#(
    parameter logic [7:0]  COMMA     = COMMA_BYTE,
    parameter int unsigned ACQ_BC    = 4,
    parameter int unsigned ERR_LIMIT = 3
) (
    input  logic       clk_4f,
    input  logic       reset,
    input  logic       link_en,
    input  logic [7:0] data_in,
    input  logic       code_err,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active,
    output logic [2:0] BC_counter,
    output logic       sync_lost,
    output logic [7:0] err_count
);

    link_state_t state, state_nxt;

    logic       bc_inc, bc_clr;
    logic       ce_inc, ce_clr;
    logic       ec_inc;
    logic       load, lose;
    logic [3:0] consec_err;
    logic       clean_comma;

    assign clean_comma = (data_in == COMMA) && !code_err;
    assign active      = (state == ST_ACTIVE);

    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            state     <= ST_DISABLED;
            data_out  <= '0;
            valid_out <= 1'b0;
            sync_lost <= 1'b0;
        end else begin
            state     <= state_nxt;
            valid_out <= load;
            sync_lost <= lose;
            if (load) begin
                data_out <= data_in;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        bc_inc    = 1'b0;
        bc_clr    = 1'b0;
        ce_inc    = 1'b0;
        ce_clr    = 1'b0;
        ec_inc    = 1'b0;
        load      = 1'b0;
        lose      = 1'b0;

        if (!link_en) begin
            state_nxt = ST_DISABLED;
            bc_clr    = 1'b1;
            ce_clr    = 1'b1;
        end else begin
            unique case (state)
                ST_DISABLED: begin
                    state_nxt = ST_HUNT;
                    bc_clr    = 1'b1;
                    ce_clr    = 1'b1;
                end
                ST_HUNT: begin
                    if (clean_comma) begin
                        bc_inc = 1'b1;
                        if (BC_counter == 3'(ACQ_BC - 1)) begin
                            state_nxt = ST_ACTIVE;
                        end
                    end else begin
                        bc_clr = 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    // BC_counter is left untouched here so it holds at ACQ_BC.
                    if (code_err) begin
                        ce_inc = 1'b1;
                        ec_inc = 1'b1;
                        if (consec_err == 4'(ERR_LIMIT - 1)) begin
                            state_nxt = ST_HUNT;
                            lose      = 1'b1;
                            bc_clr    = 1'b1;
                            ce_clr    = 1'b1;
                        end
                    end else begin
                        ce_clr = 1'b1;
                        load   = (data_in != COMMA);
                    end
                end
                default: begin
                    state_nxt = ST_DISABLED;
                    bc_clr    = 1'b1;
                    ce_clr    = 1'b1;
                end
            endcase
        end
    end

    sat_counter #(.WIDTH(3), .LIMIT(ACQ_BC)) u_bc_counter (
        .clk   (clk_4f),
        .rst   (reset),
        .clr   (bc_clr),
        .inc   (bc_inc),
        .count (BC_counter)
    );

    sat_counter #(.WIDTH(4), .LIMIT(ERR_LIMIT)) u_consec_err (
        .clk   (clk_4f),
        .rst   (reset),
        .clr   (ce_clr),
        .inc   (ce_inc),
        .count (consec_err)
    );

    sat_counter #(.WIDTH(8), .LIMIT(255)) u_err_count (
        .clk   (clk_4f),
        .rst   (reset),
        .clr   (1'b0),
        .inc   (ec_inc),
        .count (err_count)
    );

endmodule

// File: tb/tb_link_sync_ctrl.sv
// Self-checking bench for link_sync_ctrl: directed scenarios followed by
// randomized traffic, all compared against a behavioural link model.
module tb_link_sync_ctrl;

    localparam logic [7:0] BC  = 8'hBC;
    localparam int         ACQ = 4;
    localparam int         LIM = 3;

    logic       clk_4f = 1'b0;
    logic       reset  = 1'b1;
    logic       link_en = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       code_err = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;
    logic [2:0] BC_counter;
    logic       sync_lost;
    logic [7:0] err_count;

    int errors = 0;
    int checks = 0;

    // Model: link mode as text-like tags, plain integer counters.
    localparam int M_OFF = 0, M_SEARCH = 1, M_LOCKED = 2;
    int       m_mode;
    int       m_commas;
    int       m_run_err;
    int       m_total_err;
    bit [7:0] m_data;
    bit       m_valid;
    bit       m_lost;

    link_sync_ctrl #(.ACQ_BC(ACQ), .ERR_LIMIT(LIM)) dut (
        .clk_4f     (clk_4f),
        .reset      (reset),
        .link_en    (link_en),
        .data_in    (data_in),
        .code_err   (code_err),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .active     (active),
        .BC_counter (BC_counter),
        .sync_lost  (sync_lost),
        .err_count  (err_count)
    );

    always #5 clk_4f = ~clk_4f;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_OFF; m_commas = 0; m_run_err = 0; m_total_err = 0;
        m_data = 8'h00; m_valid = 1'b0; m_lost = 1'b0;
    endtask

    task automatic model_step(input bit en, input bit [7:0] d, input bit err);
        m_valid = 1'b0;
        m_lost  = 1'b0;
        if (!en) begin
            m_mode = M_OFF; m_commas = 0; m_run_err = 0;
        end else if (m_mode == M_OFF) begin
            m_mode = M_SEARCH;
        end else if (m_mode == M_SEARCH) begin
            if (!err && d == BC) begin
                m_commas++;
                if (m_commas == ACQ) m_mode = M_LOCKED;
            end else begin
                m_commas = 0;
            end
        end else begin
            if (err) begin
                if (m_total_err < 255) m_total_err++;
                m_run_err++;
                if (m_run_err == LIM) begin
                    m_mode = M_SEARCH; m_lost = 1'b1; m_commas = 0; m_run_err = 0;
                end
            end else begin
                m_run_err = 0;
                if (d != BC) begin
                    m_data = d; m_valid = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_all();
        check_eq("data_out",   data_out,   m_data);
        check_eq("valid_out",  valid_out,  m_valid);
        check_eq("active",     active,     m_mode == M_LOCKED);
        check_eq("BC_counter", BC_counter, m_commas);
        check_eq("sync_lost",  sync_lost,  m_lost);
        check_eq("err_count",  err_count,  m_total_err);
    endtask

    // Inputs are applied just after the falling edge; outputs checked on the next falling edge.
    task automatic cycle(input bit en, input bit [7:0] d, input bit err);
        link_en = en; data_in = d; code_err = err;
        @(posedge clk_4f);
        model_step(en, d, err);
        @(negedge clk_4f);
        compare_all();
    endtask

    task automatic async_reset_pulse();
        #2 reset = 1'b1;
        #1;
        check_eq("rst data_out",   data_out,   8'h00);
        check_eq("rst valid_out",  valid_out,  1'b0);
        check_eq("rst active",     active,     1'b0);
        check_eq("rst BC_counter", BC_counter, 3'd0);
        check_eq("rst sync_lost",  sync_lost,  1'b0);
        check_eq("rst err_count",  err_count,  8'h00);
        model_reset();
        #1 reset = 1'b0;
    endtask

    initial begin
        bit [7:0] seq2 [7];
        bit [7:0] d;
        bit       en, err;
        int       err_pct;

        model_reset();
        repeat (2) @(negedge clk_4f);
        compare_all();
        reset = 1'b0;

        // Acquisition: one cycle to leave DISABLED, then 4 commas.
        cycle(1, 8'h00, 0);
        for (int i = 1; i <= ACQ; i++) begin
            cycle(1, BC, 0);
            check_eq("acq step", BC_counter, i);
            check_eq("acq no valid", valid_out, 1'b0);
        end
        check_eq("acq active", active, 1'b1);

        // Broken comma run.
        cycle(0, 8'h00, 0);
        cycle(1, 8'h00, 0);
        seq2 = '{BC, BC, 8'h55, BC, BC, BC, BC};
        foreach (seq2[i]) begin
            cycle(1, seq2[i], 0);
            if (i < 6) check_eq("broken not active", active, 1'b0);
        end
        check_eq("broken active", active, 1'b1);

        // Payload forwarding with a comma in the middle.
        cycle(1, 8'h01, 0); check_eq("p01", {valid_out, data_out}, 9'h101);
        cycle(1, BC, 0);    check_eq("pbc", {valid_out, data_out}, 9'h001);
        cycle(1, 8'hFF, 0); check_eq("pff", {valid_out, data_out}, 9'h1FF);

        // Error runs: 2, clean, 3 -> loss on the 5th error.
        cycle(1, 8'h11, 1);
        cycle(1, 8'h12, 1);
        check_eq("no loss yet", active, 1'b1);
        cycle(1, 8'h02, 0);
        cycle(1, 8'h13, 1);
        cycle(1, 8'h14, 1);
        cycle(1, 8'h15, 1);
        check_eq("loss active", active, 1'b0);
        check_eq("loss pulse", sync_lost, 1'b1);
        check_eq("loss err_count", err_count, 8'd5);
        cycle(1, 8'h00, 0);
        check_eq("pulse one cycle", sync_lost, 1'b0);

        // Disable while active; re-acquire needs fresh commas.
        repeat (ACQ) cycle(1, BC, 0);
        cycle(1, 8'h33, 0);
        cycle(0, 8'h34, 0);
        check_eq("dis active", active, 1'b0);
        check_eq("dis sync_lost", sync_lost, 1'b0);
        cycle(1, BC, 0);
        repeat (ACQ - 1) cycle(1, BC, 0);
        check_eq("reacq partial", active, 1'b0);
        cycle(1, BC, 0);
        check_eq("reacq active", active, 1'b1);

        // Async reset while payload is valid.
        cycle(1, 8'h5A, 0);
        check_eq("pre-rst valid", valid_out, 1'b1);
        async_reset_pulse();

        // Randomized traffic with varying error density.
        for (int n = 0; n < 4000; n++) begin
            err_pct = ((n / 500) % 2 == 1) ? 35 : 6;
            en  = ($urandom_range(99) >= 2);
            err = ($urandom_range(99) < err_pct);
            d   = ($urandom_range(99) < 45) ? BC : 8'($urandom);
            cycle(en, d, err);
            if ($urandom_range(999) < 3) async_reset_pulse();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
